// File: rtl/rv_alu_md.sv
// RV32IM/RV64IM execute unit: single-cycle base ALU ops, iterative shift-add multiply and
// restoring divide (one bit per cycle), valid/ready handshake on both sides.
module rv_alu_md #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            flush_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [XLEN-1:0] op_1_in,
  input  logic [XLEN-1:0] op_2_in,
  input  logic [2:0]      funct3_in,
  input  logic            funct7_5_in,
  input  logic            m_ext_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] result_out,
  output logic            busy_out
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e              state_q;
  logic                valid_q;
  logic [XLEN-1:0]     result_q;
  logic [2*XLEN-1:0]   acc_q;   // product accumulator / partial remainder
  logic [2*XLEN-1:0]   sh_q;    // shifting multiplicand / divisor magnitude
  logic [XLEN-1:0]     bits_q;  // multiplier bits / dividend-in, quotient-out
  logic [SHW-1:0]      cnt_q;
  logic                s2_q, hi_q, rem_q, qneg_q, rneg_q;

  logic                accept, last;
  logic [SHW-1:0]      shamt;
  logic [XLEN-1:0]     alu_res;
  logic                m_s1, m_s2, d_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]     a_mag, b_mag, special_res;
  logic [2*XLEN-1:0]   addend, mul_acc;
  logic [XLEN:0]       trial, rem_n;
  logic                div_ge;
  logic [XLEN-1:0]     quo_n, rem_lo, div_res;

  assign ready_out  = !flush_in && ((state_q == StIdle) || (state_q == StDone && ready_in));
  assign accept     = valid_in && ready_out;
  assign valid_out  = valid_q;
  assign result_out = result_q;
  assign busy_out   = (state_q == StMul) || (state_q == StDiv);
  assign last       = (cnt_q == SHW'(XLEN - 1));
  assign shamt      = op_2_in[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (funct3_in)
      3'b000: alu_res = funct7_5_in ? op_1_in - op_2_in : op_1_in + op_2_in;
      3'b001: alu_res = op_1_in << shamt;
      3'b010: alu_res = {{(XLEN-1){1'b0}}, $signed(op_1_in) < $signed(op_2_in)};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, op_1_in < op_2_in};
      3'b100: alu_res = op_1_in ^ op_2_in;
      3'b101: begin
        // kept out of a ?: so the arithmetic shift is not coerced to unsigned
        if (funct7_5_in) alu_res = $signed(op_1_in) >>> shamt;
        else             alu_res = op_1_in >> shamt;
      end
      3'b110: alu_res = op_1_in | op_2_in;
      default: alu_res = op_1_in & op_2_in;
    endcase
  end

  always_comb begin
    m_s1        = (funct3_in[1:0] == 2'b01) || (funct3_in[1:0] == 2'b10);
    m_s2        = (funct3_in[1:0] == 2'b01);
    d_signed    = !funct3_in[0];
    a_neg       = d_signed && op_1_in[XLEN-1];
    b_neg       = d_signed && op_2_in[XLEN-1];
    a_mag       = a_neg ? -op_1_in : op_1_in;
    b_mag       = b_neg ? -op_2_in : op_2_in;
    div_zero    = (op_2_in == '0);
    div_ovf     = d_signed && (op_1_in == {1'b1, {(XLEN-1){1'b0}}}) && (&op_2_in);
    special_res = div_zero ? (funct3_in[1] ? op_1_in : '1) : (funct3_in[1] ? '0 : op_1_in);
  end

  // Signed multiplier: the top bit carries weight -2^(XLEN-1), so the last step subtracts.
  always_comb begin
    addend  = bits_q[0] ? sh_q : '0;
    mul_acc = (last && s2_q) ? acc_q - addend : acc_q + addend;
  end

  always_comb begin
    trial   = {acc_q[XLEN-1:0], bits_q[XLEN-1]};
    div_ge  = trial >= {1'b0, sh_q[XLEN-1:0]};
    rem_n   = div_ge ? trial - {1'b0, sh_q[XLEN-1:0]} : trial;
    quo_n   = {bits_q[XLEN-2:0], div_ge};
    rem_lo  = rem_n[XLEN-1:0];
    div_res = rem_q ? (rneg_q ? -rem_lo : rem_lo) : (qneg_q ? -quo_n : quo_n);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      bits_q   <= '0;
      cnt_q    <= '0;
      s2_q     <= 1'b0;
      hi_q     <= 1'b0;
      rem_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else if (flush_in) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
      if (!m_ext_in) begin
        result_q <= alu_res;
        valid_q  <= 1'b1;
        state_q  <= StDone;
      end else if (!funct3_in[2]) begin
        acc_q   <= '0;
        sh_q    <= {{XLEN{m_s1 && op_1_in[XLEN-1]}}, op_1_in};
        bits_q  <= op_2_in;
        s2_q    <= m_s2;
        hi_q    <= (funct3_in[1:0] != 2'b00);
        state_q <= StMul;
      end else if (div_zero || div_ovf) begin
        result_q <= special_res;
        valid_q  <= 1'b1;
        state_q  <= StDone;
      end else begin
        acc_q   <= '0;
        sh_q    <= {{XLEN{1'b0}}, b_mag};
        bits_q  <= a_mag;
        rem_q   <= funct3_in[1];
        qneg_q  <= a_neg ^ b_neg;
        rneg_q  <= a_neg;
        state_q <= StDiv;
      end
    end else begin
      case (state_q)
        StMul: begin
          acc_q  <= mul_acc;
          sh_q   <= sh_q << 1;
          bits_q <= bits_q >> 1;
          cnt_q  <= cnt_q + SHW'(1);
          if (last) begin
            result_q <= hi_q ? mul_acc[2*XLEN-1:XLEN] : mul_acc[XLEN-1:0];
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDiv: begin
          acc_q  <= {{(XLEN-1){1'b0}}, rem_n};
          bits_q <= quo_n;
          cnt_q  <= cnt_q + SHW'(1);
          if (last) begin
            result_q <= div_res;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          if (ready_in) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_alu_md.sv
// Bench for rv_alu_md: XLEN=32 and XLEN=64 instances, expected results queued at issue and
// compared when valid_out rises.
module tb_rv_alu_md;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush32, v_in32, rdy_out32, f75_32, m32, v_out32, rdy_in32, busy32;
  logic [31:0] a32, b32, res32;
  logic [2:0]  f3_32;
  logic        flush64, v_in64, rdy_out64, f75_64, m64, v_out64, rdy_in64, busy64;
  logic [63:0] a64, b64, res64;
  logic [2:0]  f3_64;

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  rv_alu_md #(.XLEN(32)) u_dut32 (
    .clk_in(clk), .rst_in(rst), .flush_in(flush32), .valid_in(v_in32), .ready_out(rdy_out32),
    .op_1_in(a32), .op_2_in(b32), .funct3_in(f3_32), .funct7_5_in(f75_32), .m_ext_in(m32),
    .valid_out(v_out32), .ready_in(rdy_in32), .result_out(res32), .busy_out(busy32)
  );

  rv_alu_md #(.XLEN(64)) u_dut64 (
    .clk_in(clk), .rst_in(rst), .flush_in(flush64), .valid_in(v_in64), .ready_out(rdy_out64),
    .op_1_in(a64), .op_2_in(b64), .funct3_in(f3_64), .funct7_5_in(f75_64), .m_ext_in(m64),
    .valid_out(v_out64), .ready_in(rdy_in64), .result_out(res64), .busy_out(busy64)
  );

  task automatic run_op32(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f3, input logic f75, input logic m,
                          input logic [31:0] exp, input int lat);
    int cyc, busy_n;
    logic [63:0] e;
    @(negedge clk);
    a32 = a; b32 = b; f3_32 = f3; f75_32 = f75; m32 = m; v_in32 = 1'b1; rdy_in32 = 1'b1;
    exp_q.push_back({32'b0, exp});
    @(posedge clk);
    #1 v_in32 = 1'b0; a32 = $urandom; b32 = $urandom;
    cyc = 0; busy_n = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy32 === 1'b1) busy_n++;
    end while (v_out32 !== 1'b1 && cyc < 200);
    e = exp_q.pop_front();
    n_checks++;
    if (v_out32 !== 1'b1 || cyc != lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d (valid=%b) expected %0d", name, cyc, v_out32, lat);
    end
    n_checks++;
    if (res32 !== e[31:0]) begin
      n_errors++;
      $display("FAIL %s result: got %h expected %h", name, res32, e[31:0]);
    end
    n_checks++;
    if (busy_n != lat - 1) begin
      n_errors++;
      $display("FAIL %s busy cycles: got %0d expected %0d", name, busy_n, lat - 1);
    end
  endtask

  task automatic run_op64(input string name, input logic [63:0] a, input logic [63:0] b,
                          input logic [2:0] f3, input logic m, input logic [63:0] exp,
                          input int lat);
    int cyc;
    logic [63:0] e;
    @(negedge clk);
    a64 = a; b64 = b; f3_64 = f3; f75_64 = 1'b0; m64 = m; v_in64 = 1'b1; rdy_in64 = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 v_in64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (v_out64 !== 1'b1 && cyc < 200);
    e = exp_q.pop_front();
    n_checks++;
    if (v_out64 !== 1'b1 || cyc != lat) begin
      n_errors++;
      $display("FAIL %s latency: got %0d (valid=%b) expected %0d", name, cyc, v_out64, lat);
    end
    n_checks++;
    if (res64 !== e) begin
      n_errors++;
      $display("FAIL %s result: got %h expected %h", name, res64, e);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({v_out32, busy32, rdy_out32} !== 3'b001 || res32 !== 32'h0) begin
      n_errors++;
      $display("FAIL reset32: got v=%b busy=%b rdy=%b res=%h expected 0 0 1 0",
               v_out32, busy32, rdy_out32, res32);
    end
    n_checks++;
    if ({v_out64, busy64, rdy_out64} !== 3'b001 || res64 !== 64'h0) begin
      n_errors++;
      $display("FAIL reset64: got v=%b busy=%b rdy=%b res=%h expected 0 0 1 0",
               v_out64, busy64, rdy_out64, res64);
    end
  endtask

  task automatic test_base_ops();
    run_op32("add",  32'd5,        32'd7,   3'b000, 1'b0, 1'b0, 32'd12,        1);
    run_op32("sub",  32'd0,        32'd1,   3'b000, 1'b1, 1'b0, 32'hFFFFFFFF,  1);
    run_op32("sra",  32'h80000000, 32'd4,   3'b101, 1'b1, 1'b0, 32'hF8000000,  1);
    run_op32("srl",  32'h80000000, 32'h24,  3'b101, 1'b0, 1'b0, 32'h08000000,  1);
    run_op32("slt",  32'hFFFFFFFF, 32'd1,   3'b010, 1'b0, 1'b0, 32'd1,         1);
    run_op32("sltu", 32'hFFFFFFFF, 32'd1,   3'b011, 1'b0, 1'b0, 32'd0,         1);
    run_op32("xor",  32'h0000F0F0, 32'hFF00, 3'b100, 1'b0, 1'b0, 32'h00000FF0, 1);
  endtask

  task automatic test_mul();
    run_op32("mulh",   32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001, 1'b0, 1'b1, 32'h0,         33);
    run_op32("mulhu",  32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 1'b0, 1'b1, 32'hFFFFFFFE,  33);
    run_op32("mulhsu", 32'hFFFFFFFF, 32'd2,        3'b010, 1'b0, 1'b1, 32'hFFFFFFFF,  33);
    run_op32("mul",    32'h10000,    32'h10000,    3'b000, 1'b0, 1'b1, 32'h0,         33);
    run_op32("mul_neg", 32'd7,       32'hFFFFFFFD, 3'b000, 1'b0, 1'b1, 32'hFFFFFFEB,  33);
  endtask

  task automatic test_div();
    run_op32("div",  32'hFFFFFFF9, 32'd2, 3'b100, 1'b0, 1'b1, 32'hFFFFFFFD, 33);
    run_op32("rem",  32'hFFFFFFF9, 32'd2, 3'b110, 1'b0, 1'b1, 32'hFFFFFFFF, 33);
    run_op32("divu", 32'd100,      32'd7, 3'b101, 1'b0, 1'b1, 32'd14,       33);
    run_op32("remu", 32'd100,      32'd7, 3'b111, 1'b0, 1'b1, 32'd2,        33);
  endtask

  task automatic test_div_special();
    run_op32("div_by0",  32'd5,        32'd0,        3'b100, 1'b0, 1'b1, 32'hFFFFFFFF, 1);
    run_op32("remu_by0", 32'd5,        32'd0,        3'b111, 1'b0, 1'b1, 32'd5,        1);
    run_op32("div_ovf",  32'h80000000, 32'hFFFFFFFF, 3'b100, 1'b0, 1'b1, 32'h80000000, 1);
    run_op32("rem_ovf",  32'h80000000, 32'hFFFFFFFF, 3'b110, 1'b0, 1'b1, 32'h0,        1);
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (v_out32 !== 1'b1 || res32 !== e[31:0]) begin
          n_errors++;
          $display("FAIL b2b[%0d]: got v=%b res=%h expected v=1 res=%h", i - 1, v_out32, res32,
                   e[31:0]);
        end
      end
      n_checks++;
      if (rdy_out32 !== 1'b1) begin
        n_errors++;
        $display("FAIL b2b_ready[%0d]: got %b expected 1", i, rdy_out32);
      end
      if (i < 4) begin
        a32 = 32'(i * 3); b32 = 32'd100; f3_32 = 3'b000; f75_32 = 1'b0; m32 = 1'b0;
        v_in32 = 1'b1; rdy_in32 = 1'b1;
        exp_q.push_back(64'(i * 3 + 100));
      end else begin
        v_in32 = 1'b0;
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [63:0] e;
    @(negedge clk);
    a32 = 32'd100; b32 = 32'd7; f3_32 = 3'b101; f75_32 = 1'b0; m32 = 1'b1;
    v_in32 = 1'b1; rdy_in32 = 1'b1;
    exp_q.push_back(64'd14);
    @(posedge clk);
    #1 v_in32 = 1'b0; rdy_in32 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (v_out32 !== 1'b1 && cyc < 200);
    e = exp_q.pop_front();
    n_checks++;
    if (v_out32 !== 1'b1 || cyc != 33 || res32 !== e[31:0]) begin
      n_errors++;
      $display("FAIL bp_first: got v=%b lat=%0d res=%h expected v=1 lat=33 res=%h",
               v_out32, cyc, res32, e[31:0]);
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (v_out32 !== 1'b1 || res32 !== 32'd14 || rdy_out32 !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got v=%b res=%h rdy=%b expected v=1 res=0000000e rdy=0",
                 k, v_out32, res32, rdy_out32);
      end
      a32 = 32'd1; b32 = 32'd1; f3_32 = 3'b000; m32 = 1'b0; v_in32 = 1'b1;
      @(negedge clk);
    end
    v_in32 = 1'b0; rdy_in32 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (v_out32 !== 1'b0 || rdy_out32 !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", v_out32, rdy_out32);
    end
  endtask

  task automatic test_flush();
    int seen;
    @(negedge clk);
    a32 = 32'd3; b32 = 32'd5; f3_32 = 3'b000; f75_32 = 1'b0; m32 = 1'b1;
    v_in32 = 1'b1; rdy_in32 = 1'b1;
    @(posedge clk);
    #1 v_in32 = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy32 !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_busy: got %b expected 1", busy32);
    end
    flush32 = 1'b1; v_in32 = 1'b1; m32 = 1'b0;
    #1;
    n_checks++;
    if (rdy_out32 !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_ready: got %b expected 0", rdy_out32);
    end
    @(posedge clk);
    #1 flush32 = 1'b0; v_in32 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (v_out32 !== 1'b0 || busy32 !== 1'b0 || rdy_out32 !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_idle: got v=%b busy=%b rdy=%b expected 0 0 1",
               v_out32, busy32, rdy_out32);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (v_out32 === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL flush_novalid: got %0d valid cycles expected 0", seen);
    end
  endtask

  task automatic test_xlen64();
    run_op64("sll64",   64'd1, 64'd63, 3'b001, 1'b0, 64'h8000000000000000, 1);
    run_op64("mulhu64", '1,    '1,     3'b011, 1'b1, 64'hFFFFFFFFFFFFFFFE, 65);
  endtask

  task automatic test_reset_mid_div();
    int seen;
    @(negedge clk);
    a64 = 64'd1000; b64 = 64'd3; f3_64 = 3'b100; m64 = 1'b1; v_in64 = 1'b1; rdy_in64 = 1'b1;
    @(posedge clk);
    #1 v_in64 = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy64 !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_div_busy: got %b expected 1", busy64);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({v_out64, busy64, rdy_out64} !== 3'b001 || res64 !== 64'h0) begin
      n_errors++;
      $display("FAIL rst_div_now: got v=%b busy=%b rdy=%b res=%h expected 0 0 1 0",
               v_out64, busy64, rdy_out64, res64);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (v_out64 === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_errors++;
      $display("FAIL rst_div_novalid: got %0d valid cycles expected 0", seen);
    end
  endtask

  initial begin
    flush32 = 1'b0; v_in32 = 1'b0; a32 = '0; b32 = '0; f3_32 = '0; f75_32 = 1'b0; m32 = 1'b0;
    rdy_in32 = 1'b1;
    flush64 = 1'b0; v_in64 = 1'b0; a64 = '0; b64 = '0; f3_64 = '0; f75_64 = 1'b0; m64 = 1'b0;
    rdy_in64 = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_base_ops();
    test_mul();
    test_div();
    test_div_special();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_xlen64();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
